// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the iterative divider
package div_pkg;
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quot_o
);
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;
   always_comb begin
      trial  = {rem_i, quot_i[WIDTH-1]};
      diff   = trial - {1'b0, div_i};
      rem_o  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], ~diff[WIDTH]};
   end
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/MOD/DIVU/MODU with valid/ready handshakes
module div_iter import div_pkg::*; #(
   parameter int WIDTH     = DIV_WIDTH,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             div_zero_o,
   output logic             busy_o
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quot_d;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             sgn_q;
   logic             sa_q;
   logic             sb_q;
   logic             sa;
   logic             sb;
   always_comb begin
      sa    = signed_i & op_a[WIDTH-1];
      sb    = signed_i & op_b[WIDTH-1];
      abs_a = sa ? -op_a : op_a;
      abs_b = sb ? -op_b : op_b;
   end
   assign in_ready = state_q == IDLE;
   assign busy_o   = state_q != IDLE;
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .quot_i (quot_q),
      .div_i  (dvs_q),
      .rem_o  (rem_d),
      .quot_o (quot_d)
   );
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvs_q      <= '0;
         sgn_q      <= 1'b0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         out_valid  <= 1'b0;
         quot_o     <= '0;
         rem_o      <= '0;
         div_zero_o <= 1'b0;
      end else if (flush) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               sgn_q <= signed_i;
               sa_q  <= sa;
               sb_q  <= sb;
               dvs_q <= abs_b;
               cnt_q <= '0;
               if (op_b == '0) begin
                  state_q    <= DONE;
                  out_valid  <= 1'b1;
                  quot_o     <= '1;
                  rem_o      <= op_a;
                  div_zero_o <= 1'b1;
               end else if (EARLY_OUT && abs_a < abs_b) begin
                  state_q <= FIX;
                  quot_q  <= '0;
                  rem_q   <= abs_a;
               end else begin
                  state_q <= CALC;
                  quot_q  <= abs_a;
                  rem_q   <= '0;
               end
            end
            CALC: begin
               rem_q  <= rem_d;
               quot_q <= quot_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               // quotient sign follows sign_a ^ sign_b, remainder follows the dividend
               quot_o     <= (sgn_q & (sa_q ^ sb_q)) ? -quot_q : quot_q;
               rem_o      <= (sgn_q & sa_q) ? -rem_q : rem_q;
               div_zero_o <= 1'b0;
               out_valid  <= 1'b1;
               state_q    <= DONE;
            end
            DONE: if (out_ready) begin
               state_q   <= IDLE;
               out_valid <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an arithmetic reference model
module tb_div_iter;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        signed_i = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        in_ready, out_valid, div_zero_o, busy_o;
   logic [31:0] quot_o, rem_o;
   logic        in_valid0 = 1'b0;
   logic [31:0] op_a0 = '0;
   logic [31:0] op_b0 = '0;
   logic        in_ready0, out_valid0, div_zero0, busy0;
   logic [31:0] quot0, rem0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .signed_i(signed_i), .op_a(op_a), .op_b(op_b), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .quot_o(quot_o),
      .rem_o(rem_o), .div_zero_o(div_zero_o), .busy_o(busy_o)
   );

   div_iter #(.WIDTH(32), .EARLY_OUT(1'b0)) dut_ne (
      .clk(clk), .resetn(resetn), .in_valid(in_valid0), .in_ready(in_ready0),
      .signed_i(1'b0), .op_a(op_a0), .op_b(op_b0), .flush(1'b0),
      .out_valid(out_valid0), .out_ready(1'b1), .quot_o(quot0),
      .rem_o(rem0), .div_zero_o(div_zero0), .busy_o(busy0)
   );

   // Reference: 64-bit truncating division covers MIN/-1 without special casing
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z, output int lat);
      longint la, lb, ma, mb;
      la = s ? longint'($signed(a)) : longint'(a);
      lb = s ? longint'($signed(b)) : longint'(b);
      ma = la < 0 ? -la : la;
      mb = lb < 0 ? -lb : lb;
      z = (b == 0);
      if (z) begin
         q = '1;
         r = a;
         lat = 1;
      end else begin
         q = 32'(la / lb);
         r = 32'(la % lb);
         lat = (ma < mb) ? 2 : 34;
      end
   endfunction

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat);
      int w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_wait in_ready=%b required 1", in_ready);
      end
      signed_i = s;
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      q = quot_o;
      r = rem_o;
      z = div_zero_o;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (quot_o !== 32'd0) begin failures++; $display("FAIL reset_quot got %h want 0", quot_o); end
      checks++;
      if (rem_o !== 32'd0) begin failures++; $display("FAIL reset_rem got %h want 0", rem_o); end
      checks++;
      if (div_zero_o !== 1'b0) begin failures++; $display("FAIL reset_div_zero got %b want 0", div_zero_o); end
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy_o); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic        ts [12] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1};
      logic [31:0] ta [12] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'd3,
                               32'd9, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
      logic [31:0] tb [12] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd10,
                               32'd3, 32'd0, 32'd10, 32'd1, 32'hFFFF_FFFF, 32'd7};
      logic [31:0] tq [12] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                               32'd3, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
      logic [31:0] tr [12] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5, 32'd3,
                               32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000, 32'd0};
      logic        tz [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
      int          tl [12] = '{34, 34, 34, 34, 1, 2, 34, 1, 2, 34, 2, 34};
      logic [31:0] q, r;
      logic        z;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         run_op(ts[i], ta[i], tb[i], q, r, z, lat);
         checks++;
         if (q !== tq[i]) begin failures++; $display("FAIL directed[%0d] quot got %h want %h", i, q, tq[i]); end
         checks++;
         if (r !== tr[i]) begin failures++; $display("FAIL directed[%0d] rem got %h want %h", i, r, tr[i]); end
         checks++;
         if (z !== tz[i]) begin failures++; $display("FAIL directed[%0d] div_zero got %b want %b", i, z, tz[i]); end
         checks++;
         if (lat != tl[i]) begin failures++; $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, tl[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, q, r, eq, er;
      logic        s, z, ez;
      int          lat, elat;
      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, 50);
            1: a = 32'h8000_0000;
            default: ;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 15);
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         model(s, a, b, eq, er, ez, elat);
         run_op(s, a, b, q, r, z, lat);
         checks++;
         if (q !== eq) begin failures++; $display("FAIL random[%0d] s=%b %h/%h quot got %h want %h", i, s, a, b, q, eq); end
         checks++;
         if (r !== er) begin failures++; $display("FAIL random[%0d] s=%b %h/%h rem got %h want %h", i, s, a, b, r, er); end
         checks++;
         if (z !== ez) begin failures++; $display("FAIL random[%0d] div_zero got %b want %b", i, z, ez); end
         checks++;
         if (lat != elat) begin failures++; $display("FAIL random[%0d] latency got %0d want %0d", i, lat, elat); end
      end
   endtask

   task automatic test_no_early();
      int lat = 0;
      @(negedge clk);
      checks++;
      if (in_ready0 !== 1'b1) begin failures++; $display("FAIL no_early_ready got %b want 1", in_ready0); end
      op_a0 = 32'd3;
      op_b0 = 32'd10;
      in_valid0 = 1'b1;
      @(posedge clk);
      #1 in_valid0 = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid0 && lat < 100);
      checks++;
      if (lat != 34) begin failures++; $display("FAIL no_early_latency got %0d want 34", lat); end
      checks++;
      if (quot0 !== 32'd0 || rem0 !== 32'd3 || div_zero0 !== 1'b0) begin
         failures++;
         $display("FAIL no_early_result got q=%h r=%h z=%b want q=0 r=3 z=0", quot0, rem0, div_zero0);
      end
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin failures++; $display("FAIL no_early_idle busy got %b want 0", busy0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r, eq, er, a2, b2;
      logic        z, ez;
      int          lat, elat;
      out_ready = 1'b0;
      model(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, ez, elat);
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, q, r, z, lat);
      checks++;
      if (q !== eq || r !== er) begin failures++; $display("FAIL bp_result got q=%h r=%h want q=%h r=%h", q, r, eq, er); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || quot_o !== eq || rem_o !== er) begin
            failures++;
            $display("FAIL bp_hold[%0d] got v=%b q=%h r=%h want v=1 q=%h r=%h", i, out_valid, quot_o, rem_o, eq, er);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      a2 = $urandom;
      b2 = $urandom_range(2, 1000);
      model(1'b0, a2, b2, eq, er, ez, elat);
      run_op(1'b0, a2, b2, q, r, z, lat);
      checks++;
      if (q !== eq || r !== er || lat != elat) begin
         failures++;
         $display("FAIL b2b_result got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", q, r, lat, eq, er, elat);
      end
   endtask

   task automatic test_flush();
      logic [31:0] q, r;
      logic        z;
      int          lat;
      bit          seen = 1'b0;
      @(negedge clk);
      signed_i = 1'b0;
      op_a = 32'd1000;
      op_b = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy_o !== 1'b1) begin failures++; $display("FAIL flush_busy_before got %b want 1", busy_o); end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_calc got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy_o, in_ready, out_valid);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen |= out_valid;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL flush_no_result got out_valid=1 want 0"); end
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_accept got busy=%b want 0", busy_o); end
      out_ready = 1'b0;
      run_op(1'b0, 32'd20, 32'd3, q, r, z, lat);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy_o !== 1'b0 || quot_o !== 32'd6) begin
         failures++;
         $display("FAIL flush_done got v=%b busy=%b q=%h want 0 0 6", out_valid, busy_o, quot_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q, r;
      logic        z;
      int          lat;
      @(negedge clk);
      signed_i = 1'b0;
      op_a = 32'd1000;
      op_b = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || quot_o !== 32'd0 || rem_o !== 32'd0 || div_zero_o !== 1'b0 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got v=%b q=%h r=%h z=%b busy=%b want all 0", out_valid, quot_o, rem_o, div_zero_o, busy_o);
      end
      resetn = 1'b1;
      run_op(1'b0, 32'd9, 32'd3, q, r, z, lat);
      checks++;
      if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat != 34) begin
         failures++;
         $display("FAIL reset_mid_op got q=%h r=%h z=%b lat=%0d want 3 0 0 34", q, r, z, lat);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_no_early();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
